axis_stream_fifo: RTL and testbench



---
 rtl/axis_stream_fifo.sv | 107 ++++++++++
 tb/tb_axis_stream_fifo.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_fifo.sv
// rtl/axis_stream_fifo.sv - First-word-fall-through AXI-Stream buffer FIFO with registered s_tready.
// Defining AXIS_STREAM_FIFO_PACKET_MODE_EN switches the output to store-and-forward.
module axis_stream_fifo #(
    parameter int TDATA_WIDTH = 16,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 3,
    parameter int TUSER_WIDTH = 8,
    parameter int DEPTH       = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [TDATA_WIDTH-1:0]     s_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   s_tstrb,
    input  logic [TDATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                       s_tlast,
    input  logic [TID_WIDTH-1:0]       s_tid,
    input  logic [TDEST_WIDTH-1:0]     s_tdest,
    input  logic [TUSER_WIDTH-1:0]     s_tuser,
    input  logic                       s_twakeup,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [TDATA_WIDTH-1:0]     m_tdata,
    output logic [TDATA_WIDTH/8-1:0]   m_tstrb,
    output logic [TDATA_WIDTH/8-1:0]   m_tkeep,
    output logic                       m_tlast,
    output logic [TID_WIDTH-1:0]       m_tid,
    output logic [TDEST_WIDTH-1:0]     m_tdest,
    output logic [TUSER_WIDTH-1:0]     m_tuser,
    output logic                       m_twakeup,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int KW = TDATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = TDATA_WIDTH + 2 * KW + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

    logic [WW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] level_next;
    logic          push;
    logic          pop;

    assign push  = s_tvalid & s_tready;
    assign pop   = m_tvalid & m_tready;
    assign level = wr_ptr - rd_ptr;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (!push && pop) begin
            level_next = level - 1'b1;
        end
    end

    // Pointers carry one extra bit so that full and empty remain distinguishable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            s_tready  <= 1'b0;
            m_twakeup <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            s_tready  <= (level_next < PW'(DEPTH));
            m_twakeup <= (level_next != '0) | s_twakeup;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
        end
    end

    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = mem[rd_ptr[AW-1:0]];

`ifdef AXIS_STREAM_FIFO_PACKET_MODE_EN
    logic [PW-1:0] pkt_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt <= '0;
        end else begin
            case ({push & s_tlast, pop & m_tlast})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // A full FIFO releases a partial packet so packets longer than DEPTH cannot deadlock.
    assign m_tvalid = (level != '0) && ((pkt_cnt != '0) || (level == PW'(DEPTH)));
`else
    assign m_tvalid = (level != '0);
`endif

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb/tb_axis_stream_fifo.sv - Randomized self-checking bench for axis_stream_fifo against a queue model.
module tb_axis_stream_fifo;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  strb;
        logic [1:0]  keep;
        logic        last;
        logic [1:0]  id;
        logic [2:0]  dest;
        logic [7:0]  user;
    } word_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_twakeup = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_twakeup;
    logic [LW-1:0] level;
    word_t         sw = '0;
    word_t         mw;

    logic [15:0] m_tdata;
    logic [1:0]  m_tstrb, m_tkeep;
    logic        m_tlast;
    logic [1:0]  m_tid;
    logic [2:0]  m_tdest;
    logic [7:0]  m_tuser;

    assign mw = '{data: m_tdata, strb: m_tstrb, keep: m_tkeep, last: m_tlast,
                  id: m_tid, dest: m_tdest, user: m_tuser};

    axis_stream_fifo #(
        .TDATA_WIDTH(16), .TID_WIDTH(2), .TDEST_WIDTH(3), .TUSER_WIDTH(8), .DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(sw.data), .s_tstrb(sw.strb),
        .s_tkeep(sw.keep), .s_tlast(sw.last), .s_tid(sw.id), .s_tdest(sw.dest),
        .s_tuser(sw.user), .s_twakeup(s_twakeup),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest),
        .m_tuser(m_tuser), .m_twakeup(m_twakeup), .level(level)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the buffered words in arrival order plus the two registered flags.
    word_t mq[$];
    bit    exp_rdy  = 1'b0;
    bit    exp_wake = 1'b0;

    function automatic bit exp_mvalid();
        if (mq.size() == 0) return 1'b0;
`ifdef AXIS_STREAM_FIFO_PACKET_MODE_EN
        if (mq.size() == DEPTH) return 1'b1;
        foreach (mq[i]) if (mq[i].last) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w = word_t'({$urandom, $urandom});
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_rdy  = 1'b0;
        exp_wake = 1'b0;
    endtask

    // Advance one clock from a falling edge to the next, updating the model with the handshakes.
    task automatic tick();
        bit push, pop;
        push = s_tvalid && exp_rdy;
        pop  = exp_mvalid() && m_tready;
        @(posedge aclk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(sw);
        exp_rdy  = (mq.size() < DEPTH);
        exp_wake = (mq.size() != 0) || s_twakeup;
        @(negedge aclk);
    endtask

    task automatic drain();
        s_twakeup = 1'b0;
        m_tready  = 1'b1;
        for (int c = 0; c < 40 && mq.size() != 0; c++) begin
            sw      = rand_word();
            sw.last = 1'b1;
            s_tvalid = !exp_mvalid() && exp_rdy;
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        n_tests++;
        if (level !== '0 || mq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: level %0d model %0d required 0", level, mq.size());
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        model_reset();
        @(negedge aclk);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || level !== '0 || m_twakeup !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: s_tready %b m_tvalid %b level %0d wake %b required 0",
                         s_tready, m_tvalid, level, m_twakeup);
            end
            @(negedge aclk);
        end
        aresetn = 1'b1;
        #1;
        n_tests++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready_early: got %b required 0", s_tready);
        end
        @(negedge aclk);
        exp_rdy = 1'b1;
        n_tests++;
        if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || level !== '0) begin
            n_fail++;
            $display("FAIL reset_release: s_tready %b m_tvalid %b level %0d required 1 0 0",
                     s_tready, m_tvalid, level);
        end
    endtask

    task automatic test_single_word();
        word_t w;
        w = '{data: 16'hA55A, strb: 2'b11, keep: 2'b11, last: 1'b1, id: 2'd2, dest: 3'd5, user: 8'h3C};
        m_tready = 1'b0;
        sw = w;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        sw = rand_word();
        n_tests++;
        if (m_tvalid !== 1'b1 || mw !== w || level !== LW'(1)) begin
            n_fail++;
            $display("FAIL single_word: valid %b word %h level %0d required 1 %h 1", m_tvalid, mw, level, w);
        end
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        n_tests++;
        if (m_tvalid !== 1'b0 || level !== '0) begin
            n_fail++;
            $display("FAIL single_pop: valid %b level %0d required 0 0", m_tvalid, level);
        end
    endtask

    task automatic test_fill_backpressure();
        m_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            sw = rand_word();
            sw.data = 16'(i);
            sw.last = 1'b0;
            s_tvalid = 1'b1;
            tick();
        end
        n_tests++;
        if (s_tready !== 1'b0 || level !== LW'(4) || m_tvalid !== 1'b1 || m_tdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL fill_full: ready %b level %0d valid %b data %h required 0 4 1 0001",
                     s_tready, level, m_tvalid, m_tdata);
        end
        sw = rand_word();
        sw.data = 16'h0005;
        sw.last = 1'b1;
        tick();
        tick();
        n_tests++;
        if (level !== LW'(4) || m_tdata !== 16'h0001) begin
            n_fail++;
            $display("FAIL fill_hold: level %0d data %h required 4 0001", level, m_tdata);
        end
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        n_tests++;
        if (s_tready !== 1'b1 || level !== LW'(3) || m_tdata !== 16'h0002) begin
            n_fail++;
            $display("FAIL fill_pop: ready %b level %0d data %h required 1 3 0002", s_tready, level, m_tdata);
        end
        tick();
        s_tvalid = 1'b0;
        n_tests++;
        if (level !== LW'(4) || mq[DEPTH-1].data !== 16'h0005) begin
            n_fail++;
            $display("FAIL fill_fifth: level %0d required 4", level);
        end
        drain();
    endtask

    task automatic test_streaming();
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sw = rand_word();
            sw.data = 16'(i);
            sw.last = 1'b1;
            s_tvalid = 1'b1;
            tick();
            n_tests++;
            if (m_tvalid !== 1'b1 || level !== LW'(1) || m_tdata !== 16'(i) || s_tready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: valid %b level %0d data %h ready %b required 1 1 %h 1",
                         i, m_tvalid, level, m_tdata, s_tready, 16'(i));
            end
        end
        s_tvalid = 1'b0;
        tick();
        m_tready = 1'b0;
        n_tests++;
        if (level !== '0 || m_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: level %0d valid %b required 0 0", level, m_tvalid);
        end
    endtask

    task automatic test_wakeup();
        s_twakeup = 1'b1;
        n_tests++;
        if (m_twakeup !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_pre: got %b required 0", m_twakeup);
        end
        tick();
        s_twakeup = 1'b0;
        n_tests++;
        if (m_twakeup !== 1'b1) begin
            n_fail++;
            $display("FAIL wake_on: got %b required 1", m_twakeup);
        end
        tick();
        n_tests++;
        if (m_twakeup !== 1'b0) begin
            n_fail++;
            $display("FAIL wake_off: got %b required 0", m_twakeup);
        end
    endtask

`ifdef AXIS_STREAM_FIFO_PACKET_MODE_EN
    task automatic test_packet_mode();
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw = rand_word();
            sw.last = (i == 2);
            s_tvalid = 1'b1;
            tick();
            n_tests++;
            if (m_tvalid !== (i == 2)) begin
                n_fail++;
                $display("FAIL pkt_saf_%0d: valid %b required %b", i, m_tvalid, (i == 2));
            end
        end
        s_tvalid = 1'b0;
        drain();
        for (int i = 0; i < 4; i++) begin
            sw = rand_word();
            sw.last = 1'b0;
            s_tvalid = 1'b1;
            tick();
            n_tests++;
            if (m_tvalid !== (i == 3)) begin
                n_fail++;
                $display("FAIL pkt_full_%0d: valid %b required %b", i, m_tvalid, (i == 3));
            end
        end
        s_tvalid = 1'b0;
        drain();
    endtask
`else
    task automatic test_cut_through();
        m_tready = 1'b0;
        sw = rand_word();
        sw.last = 1'b0;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
        n_tests++;
        if (m_tvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL cut_through: valid %b required 1", m_tvalid);
        end
        drain();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            sw        = rand_word();
            s_tvalid  = ($urandom_range(0, 3) != 0);
            m_tready  = ($urandom_range(0, 2) != 0);
            s_twakeup = ($urandom_range(0, 7) == 0);
            n_tests++;
            if (s_tready !== exp_rdy || m_tvalid !== exp_mvalid() || level !== LW'(mq.size())
                || m_twakeup !== exp_wake || (exp_mvalid() && mw !== mq[0])) begin
                n_fail++;
                $display("FAIL random_%0d: ready %b/%b valid %b/%b level %0d/%0d wake %b/%b word %h",
                         c, s_tready, exp_rdy, m_tvalid, exp_mvalid(), level, mq.size(),
                         m_twakeup, exp_wake, mw);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sw = rand_word();
            sw.last = 1'b1;
            s_tvalid = 1'b1;
            tick();
        end
        #2 aresetn = 1'b0;
        #1;
        model_reset();
        s_tvalid = 1'b0;
        n_tests++;
        if (m_tvalid !== 1'b0 || level !== '0 || s_tready !== 1'b0 || m_twakeup !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid %b level %0d ready %b wake %b required 0 0 0 0",
                     m_tvalid, level, s_tready, m_twakeup);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        n_tests++;
        if (m_tvalid !== 1'b0 || level !== '0 || s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release: valid %b level %0d ready %b required 0 0 1",
                     m_tvalid, level, s_tready);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_backpressure();
        test_streaming();
        test_wakeup();
`ifdef AXIS_STREAM_FIFO_PACKET_MODE_EN
        test_packet_mode();
`else
        test_cut_through();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
